// File: rtl/invaders_int_ctrl_if.sv
// invaders_int_ctrl_if: CPU-side interrupt request/acknowledge bus between i8080 and the responder
interface invaders_int_ctrl_if;
  logic inte;
  logic inta;
  logic int_req;
  logic [7:0] data_out;
  logic data_oe;
  modport master (output inte, inta, input int_req, data_out, data_oe);
  modport slave (input inte, inta, output int_req, data_out, data_oe);
endinterface

// File: rtl/invaders_int_ctrl.sv
// invaders_int_ctrl: turns mid/end-of-screen strobes into 8080 interrupts and answers INTA with an RST opcode
module invaders_int_ctrl #(
  parameter int MID_VEC = 1,
  parameter int END_VEC = 2,
  parameter logic [7:0] SPUR_OP = 8'hFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mid_stb,
  input  logic end_stb,
  input  logic ovr_clr,
  invaders_int_ctrl_if.slave cpu,
  output logic [1:0] overrun,
  output logic [7:0] spur_cnt
);
  localparam logic [7:0] MID_OP = 8'hC7 | 8'(MID_VEC << 3);
  localparam logic [7:0] END_OP = 8'hC7 | 8'(END_VEC << 3);
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t state, state_next;
  logic inta_q, acc;
  logic [1:0] pend, pend_next, win, ovr_set;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    acc = (state == IDLE) && cpu.inta && !inta_q;
    state_next = (state == IDLE) ? (acc ? DRIVE : IDLE) : (cpu.inta ? DRIVE : IDLE);
  end
  always_comb cpu.data_oe = (state == DRIVE);
  // a strobe landing on its own acceptance edge is a fresh request, not an overrun
  always_comb begin
    win = {acc & ~pend[0] & pend[1], acc & pend[0]};
    pend_next = {end_stb, mid_stb} | (pend & ~win);
    ovr_set = {end_stb, mid_stb} & pend & ~win;
  end
  // inta_q resets high so an acknowledge already in progress at release is not taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inta_q <= 1'b1;
      pend <= '0;
      overrun <= '0;
      spur_cnt <= '0;
      cpu.int_req <= 1'b0;
      cpu.data_out <= '0;
    end else begin
      inta_q <= cpu.inta;
      pend <= pend_next;
      overrun <= (ovr_clr ? 2'b00 : overrun) | ovr_set;
      cpu.int_req <= cpu.inte & |pend_next & (state_next == IDLE);
      if (acc) cpu.data_out <= win[0] ? MID_OP : win[1] ? END_OP : SPUR_OP;
      if (acc && !(|pend) && spur_cnt != 8'hFF) spur_cnt <= spur_cnt + 8'd1;
    end
endmodule

// File: tb/tb_invaders_int_ctrl.sv
// tb_invaders_int_ctrl: directed stimulus with an opcode scoreboard checked by an acknowledge monitor
module tb_invaders_int_ctrl;
  logic clk = 0, rst_n = 0, mid_stb = 0, end_stb = 0, ovr_clr = 0;
  logic [1:0] overrun;
  logic [7:0] spur_cnt, held;
  logic oe_q = 0;
  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];
  invaders_int_ctrl_if b();
  invaders_int_ctrl dut (.clk(clk), .rst_n(rst_n), .mid_stb(mid_stb), .end_stb(end_stb),
    .ovr_clr(ovr_clr), .cpu(b.slave), .overrun(overrun), .spur_cnt(spur_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic m, input logic e);
    mid_stb = m;
    end_stb = e;
    cyc(1);
    mid_stb = 0;
    end_stb = 0;
  endtask
  task automatic ack(input int n, input logic [7:0] op);
    exp_q.push_back(op);
    b.inta = 1;
    cyc(1);
    chk("ack_oe", b.data_oe, 1);
    chk("ack_int_req_low", b.int_req, 0);
    cyc(n - 1);
    b.inta = 0;
    cyc(1);
    chk("ack_oe_end", b.data_oe, 0);
  endtask
  always @(negedge clk) begin
    if (b.data_oe && !oe_q) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ack_unexpected: got %0h expected none", b.data_out);
      end else chk("ack_opcode", b.data_out, exp_q.pop_front());
      held <= b.data_out;
    end else if (b.data_oe) chk("ack_hold", b.data_out, held);
    oe_q <= b.data_oe;
  end
  initial begin
    b.inte = 0;
    b.inta = 0;
    cyc(2);
    chk("rst_int_req", b.int_req, 0);
    chk("rst_oe", b.data_oe, 0);
    chk("rst_data", b.data_out, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_spur", spur_cnt, 0);
    rst_n = 1;
    b.inte = 1;
    cyc(1);
    pulse(1, 0);
    chk("mid_req", b.int_req, 1);
    ack(3, 8'hCF);
    chk("mid_done_req", b.int_req, 0);
    pulse(1, 1);
    chk("prio_req", b.int_req, 1);
    ack(3, 8'hCF);
    chk("prio_rereq", b.int_req, 1);
    ack(3, 8'hD7);
    chk("prio_done_req", b.int_req, 0);
    b.inte = 0;
    pulse(0, 1);
    for (int i = 0; i < 10; i++) begin
      chk("inte_gate", b.int_req, 0);
      cyc(1);
    end
    b.inte = 1;
    cyc(1);
    chk("inte_raise", b.int_req, 1);
    ack(2, 8'hD7);
    pulse(1, 0);
    cyc(1);
    pulse(1, 0);
    chk("ovr_set", overrun, 2'b01);
    ack(2, 8'hCF);
    chk("ovr_single_req", b.int_req, 0);
    ovr_clr = 1;
    cyc(1);
    ovr_clr = 0;
    chk("ovr_clr", overrun, 0);
    pulse(1, 0);
    exp_q.push_back(8'hCF);
    b.inta = 1;
    mid_stb = 1;
    cyc(1);
    mid_stb = 0;
    chk("acc_stb_no_ovr", overrun, 0);
    chk("acc_stb_req_low", b.int_req, 0);
    cyc(1);
    b.inta = 0;
    cyc(1);
    chk("acc_stb_pend", b.int_req, 1);
    chk("acc_stb_no_ovr2", overrun, 0);
    mid_stb = 1;
    ovr_clr = 1;
    cyc(1);
    mid_stb = 0;
    ovr_clr = 0;
    chk("clr_vs_set", overrun, 2'b01);
    ack(2, 8'hCF);
    ovr_clr = 1;
    cyc(1);
    ovr_clr = 0;
    ack(2, 8'hFF);
    chk("spur_one", spur_cnt, 1);
    for (int i = 0; i < 256; i++) ack(2, 8'hFF);
    chk("spur_sat", spur_cnt, 255);
    pulse(1, 0);
    cyc(1);
    pulse(1, 0);
    pulse(0, 1);
    exp_q.push_back(8'hCF);
    b.inta = 1;
    cyc(1);
    chk("pre_rst_oe", b.data_oe, 1);
    chk("pre_rst_ovr", overrun, 2'b01);
    #2 rst_n = 0;
    #1;
    chk("rst_async_oe", b.data_oe, 0);
    chk("rst_async_req", b.int_req, 0);
    chk("rst_async_ovr", overrun, 0);
    chk("rst_async_data", b.data_out, 0);
    chk("rst_async_spur", spur_cnt, 0);
    cyc(1);
    rst_n = 1;
    cyc(2);
    chk("rst_no_accept", b.data_oe, 0);
    chk("rst_pend_clear", b.int_req, 0);
    b.inta = 0;
    cyc(1);
    ack(2, 8'hFF);
    chk("rst_spur_after", spur_cnt, 1);
    cyc(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/invaders_int_ctrl.md
# invaders_int_ctrl

Interrupt responder for the Space Invaders system: converts the video timing's mid-screen and end-of-screen strobes into 8080 interrupt requests. It answers the CPU's interrupt-acknowledge cycle by driving a single-byte RST opcode onto the CPU data-in path. It sits in `invaders` between the video timing generator and `i8080`. It is the responder for the acknowledge fetch that the CPU initiates at M1.

## Interface

- `MID_VEC`, 1: RST number served for the mid-screen strobe. Opcode is `8'hC7 | (MID_VEC << 3)`, i.e. `8'hCF` by default.
- `END_VEC`, 2: RST number served for the end-of-screen strobe. Opcode is `8'hD7` by default.
- `SPUR_OP`, `8'hFF`: opcode driven for an acknowledge with nothing pending (open-bus RST 7).
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mid_stb` in 1: one-cycle pulse, synchronous to `clk`, at the mid-screen line.
- `end_stb` in 1: one-cycle pulse, synchronous to `clk`, at the start of vblank.
- `inte` in 1: CPU interrupt-enable flip-flop.
- `inta` in 1: CPU interrupt acknowledge; high for ≥2 cycles of the acknowledge M1.
- `ovr_clr` in 1: clears `overrun`.
- `int_req` out 1: interrupt request to the CPU (registered).
- `data_out` out 8: opcode for the acknowledge fetch (registered).
- `data_oe` out 1: `data_out` is valid; the top muxes it over memory data.
- `overrun` out 2: sticky; bit0 is mid, bit1 is end. Set when a strobe hits an already-pending request.
- `spur_cnt` out 8: saturating count of acknowledges taken with nothing pending.

## Operation

- **Pending bits.** `pend[0]` (mid) and `pend[1]` (end).
  - A strobe sets its bit.
  - A strobe whose bit is already set and not being accepted this cycle sets the matching `overrun` bit; the request count stays 1.
- **States.**
  - `IDLE`: `inta` rising (`inta` high and previously low) goes to `DRIVE`.
  - `DRIVE`: `inta` low returns to `IDLE`.
- **Acceptance** happens on the `IDLE`→`DRIVE` edge.
  - Winner: mid if `pend[0]`, else end if `pend[1]`. Mid wins when both are set.
  - The winner's pending bit is cleared.
  - `data_out` loads the winner's opcode, or `SPUR_OP` with `spur_cnt` +1 (saturating at 255) if nothing is pending.
- **`DRIVE`:** `data_oe`=1 and `data_out` is held constant for the whole state.
- **`int_req`** next value is `inte & |pend_next & (state_next == IDLE)`.
  - With `inte` low, pending bits are retained and `int_req` is 0.
- **Strobe in the acceptance cycle** for the same source: the bit stays set (a new request). No overrun is flagged.
- **`ovr_clr` and a strobe in the same cycle:** the set wins.
- **`inta` staying high** never causes a second acceptance. A new acceptance requires `inta` to go low and then rise again.
- **Reset**, asynchronous and usable mid-acknowledge, immediately forces:
  - state `IDLE`
  - `int_req`=0, `data_oe`=0, `data_out`=8'h00
  - `pend`=0, `overrun`=0, `spur_cnt`=0

## Timing

- **Strobe to request:** strobe at edge N sets `pend` at N; `int_req`=1 after edge N (1 cycle), provided `inte`=1.
- **Acknowledge to data:** `inta` sampled high at edge K. After K, `data_oe`=1, `data_out` is valid and `int_req`=0. The CPU samples data no earlier than the 2nd `inta` cycle.
- **End of drive:** `inta` sampled low at edge J; `data_oe`=0 after J.
- **Second pending source:** if another source is still pending, `int_req` re-asserts after J when `inte`=1. The CPU clears INTE on acknowledge, so in practice it re-asserts after EI.
- **Overrun:** `overrun` sets on the edge of the offending strobe and clears on the edge after `ovr_clr`.

## Test plan

- **Mid request:** `mid_stb` pulse, `inte`=1 → `int_req`=1 next cycle. Then `inta` high 3 cycles → `data_out`=8'hCF, `data_oe`=1 from cycle after first `inta` sample until `inta` falls. `int_req`=0, `pend`=0.
- **Priority:** `mid_stb` and `end_stb` in the same cycle → first acknowledge gives 8'hCF, second gives 8'hD7. `int_req` is low between them while `inta` is high.
- **INTE gating:** `end_stb` with `inte`=0 → `int_req` stays 0 for 10 cycles. Raise `inte` → `int_req`=1 next edge. Acknowledge → 8'hD7.
- **Overrun:** two `mid_stb` pulses with no acknowledge → `overrun`=2'b01 and one acknowledge serves 8'hCF. `ovr_clr` → `overrun`=0. A strobe on the acceptance edge → `pend[0]` stays 1 with no overrun.
- **Spurious acknowledge:** `inta` with nothing pending → `data_out`=8'hFF and `spur_cnt`=1. After 256 spurious acknowledges `spur_cnt`=255.
- **Reset mid-drive:** `rst_n` low during `DRIVE` → `data_oe`, `int_req`, `pend` and `overrun` read 0 immediately, before the next edge. After release with `inta` still high, there is no acceptance until `inta` falls and rises again.
